// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout, TX FSM states and the divisor clamp.
package uart_tx_periph_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [15:0] MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Field order matches the STATUS bit positions above (ovf is bit 3).
    typedef struct packed {
        logic ovf;
        logic busy;
        logic empty;
        logic full;
    } status_t;

    function automatic logic [15:0] effective_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO with a combinational head output. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; the count gates every
    // read, so stale contents are never observed and the RAM stays reset-free.
    always_ff @(posedge sys_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// UART transmitter peripheral: register file on the decoded system bus, a TX
// FIFO, and an 8N1 serialiser that runs frames back-to-back while data waits.
module uart_tx_periph #(
    parameter int DEFAULT_DIV = 434,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        sys_clk,
    input  logic        sys_resetn,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        tx_irq
);

    import uart_tx_periph_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(DEFAULT_DIV);
    localparam logic [CW:0] CNT_FULL  = (CW+1)'(FIFO_DEPTH);

    logic [15:0] div_q;
    logic        ovf_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_word;
    status_t     status;

    logic        wr_txdata;
    logic        wr_status;
    logic        wr_bauddiv;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW:0] fifo_count;

    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] fdiv_q, fdiv_d;
    logic        tx_q, tx_d;
    logic        irq_q;
    logic        load_frame;
    logic [15:0] next_div;

    logic        unused_bits;
    assign unused_bits = &{1'b0, bus_wdata[31:16], bus_wstrb[3:2]};

    assign wr_txdata  = bus_write && (bus_addr == REG_TXDATA) && bus_wstrb[0];
    assign wr_status  = bus_write && (bus_addr == REG_STATUS) && bus_wstrb[0];
    assign wr_bauddiv = bus_write && (bus_addr == REG_BAUDDIV);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .push       (wr_txdata),
        .pop        (fifo_pop),
        .din        (bus_wdata[7:0]),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign status.ovf   = ovf_q;
    assign status.busy  = (state_q != ST_IDLE);
    assign status.empty = (fifo_count == '0);
    assign status.full  = (fifo_count == CNT_FULL);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (bus_addr)
            REG_STATUS:  rd_word = {28'd0, status};
            REG_BAUDDIV: rd_word = {16'd0, div_q};
            default:     rd_word = '0;
        endcase
    end

    // A same-cycle read and write returns the pre-write value because rd_word
    // is built from the current register contents.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            rdata_q <= '0;
            div_q   <= DIV_RESET;
            ovf_q   <= 1'b0;
        end else begin
            if (bus_read) begin
                rdata_q <= rd_word;
            end
            if (wr_bauddiv && bus_wstrb[0]) begin
                div_q[7:0] <= bus_wdata[7:0];
            end
            if (wr_bauddiv && bus_wstrb[1]) begin
                div_q[15:8] <= bus_wdata[15:8];
            end
            if (wr_txdata && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end else if (wr_status && bus_wdata[STAT_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus_rdata = rdata_q;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    assign next_div = effective_div(div_q);

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        fdiv_d     = fdiv_q;
        fifo_pop   = 1'b0;
        load_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_frame = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = fdiv_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = fdiv_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Divisor is sampled only here, so a mid-frame BAUDDIV write waits
        // for the next frame.
        if (load_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            fdiv_d   = next_div;
            cnt_d    = next_div - 16'd1;
            state_d  = ST_START;
        end

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            fdiv_q  <= MIN_DIV;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            fdiv_q  <= fdiv_d;
            tx_q    <= tx_d;
            irq_q   <= fifo_empty && (state_q == ST_IDLE);
        end
    end

    assign uart_tx = tx_q;
    assign tx_irq  = irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: register map, 8N1 waveforms against
// a frame-level model, FIFO full/overflow and asynchronous reset.
module tb_uart_tx_periph;

    logic        sys_clk    = 1'b0;
    logic        sys_resetn = 1'b0;
    logic        bus_read   = 1'b0;
    logic        bus_write  = 1'b0;
    logic [1:0]  bus_addr   = 2'd0;
    logic [31:0] bus_wdata  = '0;
    logic [3:0]  bus_wstrb  = '0;
    wire  [31:0] bus_rdata;
    wire         uart_tx;
    wire         tx_irq;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_periph #(
        .DEFAULT_DIV (434),
        .FIFO_DEPTH  (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_resetn (sys_resetn),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rdata  (bus_rdata),
        .uart_tx    (uart_tx),
        .tx_irq     (tx_irq)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    function automatic int eff_div(input int div);
        return (div < 2) ? 2 : div;
    endfunction

    function automatic logic [511:0] model_wave(input logic [7:0] b [4], input int d [4], input int n);
        logic [511:0] w = '0;
        int pos = 0;
        logic bv;
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < 10; k++) begin
                if (k == 0) bv = 1'b0;
                else if (k == 9) bv = 1'b1;
                else bv = b[f][k-1];
                for (int r = 0; r < d[f]; r++) begin
                    w[pos] = bv;
                    pos++;
                end
            end
        end
        return w;
    endfunction

    function automatic int model_len(input int d [4], input int n);
        int len = 0;
        for (int f = 0; f < n; f++) len += 10 * d[f];
        return len;
    endfunction

    function automatic logic [511:0] frame_mask(input int len);
        logic [511:0] m = '0;
        for (int i = 1; i < len; i++) m[i] = 1'b1;
        return m;
    endfunction

    // ---------------- bus / capture helpers ----------------
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_addr  = a;
        bus_wdata = d;
        bus_wstrb = s;
        bus_write = 1'b1;
        @(negedge sys_clk);
        bus_write = 1'b0;
        bus_wstrb = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        bus_read = 1'b1;
        @(negedge sys_clk);
        bus_read = 1'b0;
        d = bus_rdata;
    endtask

    // Waits (bounded) for a start bit, then records len samples of the line.
    // With rd_status set, STATUS is read continuously to record busy.
    task automatic capture(input int len, input bit rd_status, output logic [511:0] wave,
                           output logic [511:0] busy, output logic [511:0] irq, output int lat);
        wave = '0;
        busy = '0;
        irq  = '0;
        lat  = -1;
        if (rd_status) begin
            bus_addr = 2'd1;
            bus_read = 1'b1;
        end
        for (int w = 0; w < 8; w++) begin
            if (uart_tx === 1'b0) begin
                lat = w;
                break;
            end
            @(negedge sys_clk);
        end
        if (lat >= 0) begin
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge sys_clk);
                wave[i] = uart_tx;
                busy[i] = bus_rdata[2];
                irq[i]  = tx_irq;
            end
        end
        bus_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge sys_clk);
            if (tx_irq === 1'b1 && uart_tx === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        vectors++;
        if (tx_irq !== 1'b1) begin miscompares++; $display("FAIL reset_irq: got %b expected 1", tx_irq); end
        vectors++;
        if (bus_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", bus_rdata); end
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h0000_0002) begin miscompares++; $display("FAIL reset_status: got %h expected 00000002", r); end
        bus_rd(2'd2, r);
        vectors++;
        if (r !== 32'h0000_01B2) begin miscompares++; $display("FAIL reset_bauddiv: got %h expected 000001b2", r); end
        bus_rd(2'd0, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("FAIL read_txdata: got %h expected 0", r); end
        bus_rd(2'd3, r);
        vectors++;
        if (r !== 32'd0) begin miscompares++; $display("FAIL read_off3: got %h expected 0", r); end
    endtask

    task automatic test_single_frame();
        logic [7:0]   b [4] = '{8'hA5, 8'h00, 8'h00, 8'h00};
        int           d [4] = '{4, 4, 4, 4};
        logic [511:0] wave, busy, irq, exp_w, m;
        int           lat, len;
        bus_wr(2'd2, 32'd4, 4'b0011);
        bus_wr(2'd0, 32'h0000_00A5, 4'b0001);
        len   = model_len(d, 1);
        exp_w = model_wave(b, d, 1);
        m     = frame_mask(len);
        capture(len, 1'b1, wave, busy, irq, lat);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("FAIL a5_start_latency: got %0d expected 1", lat); end
        vectors++;
        if (wave !== exp_w) begin miscompares++; $display("FAIL a5_wave: got %h expected %h", wave[63:0], exp_w[63:0]); end
        vectors++;
        if ((busy & m) !== m) begin miscompares++; $display("FAIL a5_busy: got %h expected %h", busy[63:0], m[63:0]); end
        vectors++;
        if ((irq & m) !== '0) begin miscompares++; $display("FAIL a5_irq_during: got %h expected 0", irq[63:0]); end
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (tx_irq !== 1'b1) begin miscompares++; $display("FAIL a5_irq_after: got %b expected 1", tx_irq); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]   b [4] = '{8'h55, 8'h0F, 8'h00, 8'h00};
        int           d [4] = '{2, 2, 2, 2};
        logic [511:0] wave, busy, irq, exp_w;
        int           lat, len;
        bit           ok;
        bus_wr(2'd2, 32'd2, 4'b0011);
        len   = model_len(d, 2);
        exp_w = model_wave(b, d, 2);
        fork
            begin
                bus_wr(2'd0, 32'h55, 4'b0001);
                bus_wr(2'd0, 32'h0F, 4'b0001);
            end
            capture(len, 1'b0, wave, busy, irq, lat);
        join
        vectors++;
        if (lat < 0 || wave !== exp_w) begin
            miscompares++;
            $display("FAIL b2b_wave: got %h expected %h (lat %0d)", wave[63:0], exp_w[63:0], lat);
        end
        wait_idle(50, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_idle: got busy expected idle"); end
    endtask

    task automatic test_div_change();
        logic [7:0]   b [4];
        int           d [4] = '{4, 8, 0, 0};
        logic [511:0] wave, busy, irq, exp_w;
        int           lat, len;
        bit           ok;
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        b[2] = 8'h00;
        b[3] = 8'h00;
        bus_wr(2'd2, 32'd4, 4'b0011);
        len   = model_len(d, 2);
        exp_w = model_wave(b, d, 2);
        fork
            begin
                bus_wr(2'd0, {24'd0, b[0]}, 4'b0001);
                bus_wr(2'd0, {24'd0, b[1]}, 4'b0001);
                repeat (10) @(negedge sys_clk);
                bus_wr(2'd2, 32'd8, 4'b0011);
            end
            capture(len, 1'b0, wave, busy, irq, lat);
        join
        vectors++;
        if (lat < 0 || wave !== exp_w) begin
            miscompares++;
            $display("FAIL div_change_wave: got %h expected %h (lat %0d)", wave[127:0], exp_w[127:0], lat);
        end
        wait_idle(50, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL div_change_idle: got busy expected idle"); end
    endtask

    task automatic test_random_frames();
        logic [7:0]   b [4];
        int           d [4];
        logic [511:0] wave, busy, irq, exp_w;
        int           lat, len, n, div;
        bit           ok;
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(2, 6);
            n   = $urandom_range(1, 3);
            for (int f = 0; f < 4; f++) begin
                b[f] = 8'($urandom);
                d[f] = div;
            end
            bus_wr(2'd2, 32'(div), 4'b0011);
            len   = model_len(d, n);
            exp_w = model_wave(b, d, n);
            fork
                for (int f = 0; f < n; f++) bus_wr(2'd0, {24'd0, b[f]}, 4'b0001);
                capture(len, 1'b0, wave, busy, irq, lat);
            join
            vectors++;
            if (lat < 0 || wave !== exp_w) begin
                miscompares++;
                $display("FAIL rand_wave[%0d]: div %0d n %0d got %h expected %h", it, div, n, wave[191:0], exp_w[191:0]);
            end
            wait_idle(50, ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL rand_idle[%0d]: got busy expected idle", it); end
        end
    endtask

    task automatic test_min_div();
        logic [7:0]   b [4];
        int           d [4];
        logic [511:0] wave, busy, irq, exp_w;
        logic [31:0]  r;
        int           lat, len;
        bit           ok;
        b    = '{8'h00, 8'h00, 8'h00, 8'h00};
        b[0] = 8'($urandom);
        d    = '{eff_div(1), 0, 0, 0};
        bus_wr(2'd2, 32'd1, 4'b0011);
        bus_rd(2'd2, r);
        vectors++;
        if (r !== 32'd1) begin miscompares++; $display("FAIL min_div_read: got %h expected 00000001", r); end
        len   = model_len(d, 1);
        exp_w = model_wave(b, d, 1);
        fork
            bus_wr(2'd0, {24'd0, b[0]}, 4'b0001);
            capture(len, 1'b0, wave, busy, irq, lat);
        join
        vectors++;
        if (lat < 0 || wave !== exp_w) begin
            miscompares++;
            $display("FAIL min_div_wave: got %h expected %h", wave[31:0], exp_w[31:0]);
        end
        wait_idle(50, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL min_div_idle: got busy expected idle"); end
    endtask

    task automatic test_strobes();
        logic [31:0] r;
        bus_wr(2'd0, 32'h77, 4'b1110);
        repeat (3) @(negedge sys_clk);
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL nostrb_tx: got %b expected 1", uart_tx); end
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h2) begin miscompares++; $display("FAIL nostrb_status: got %h expected 00000002", r); end
        bus_wr(2'd2, 32'h0000_1234, 4'b1111);
        bus_wr(2'd2, 32'hFFFF_ABCD, 4'b0010);
        bus_rd(2'd2, r);
        vectors++;
        if (r !== 32'h0000_AB34) begin miscompares++; $display("FAIL div_strobe: got %h expected 0000ab34", r); end
        bus_addr  = 2'd2;
        bus_wdata = 32'd5;
        bus_wstrb = 4'b1111;
        bus_write = 1'b1;
        bus_read  = 1'b1;
        @(negedge sys_clk);
        bus_write = 1'b0;
        bus_read  = 1'b0;
        bus_wstrb = '0;
        vectors++;
        if (bus_rdata !== 32'h0000_AB34) begin miscompares++; $display("FAIL rd_wr_same: got %h expected 0000ab34", bus_rdata); end
        bus_rd(2'd2, r);
        vectors++;
        if (r !== 32'd5) begin miscompares++; $display("FAIL rd_after_wr: got %h expected 00000005", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bit          ok;
        bus_wr(2'd2, 32'd16, 4'b0011);
        for (int i = 0; i < 9; i++) bus_wr(2'd0, 32'($urandom), 4'b0001);
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h5) begin miscompares++; $display("FAIL fifo_full_status: got %h expected 00000005", r); end
        bus_wr(2'd0, 32'hEE, 4'b0001);
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'hD) begin miscompares++; $display("FAIL ovf_status: got %h expected 0000000d", r); end
        bus_wr(2'd1, 32'h8, 4'b0001);
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h5) begin miscompares++; $display("FAIL ovf_clear: got %h expected 00000005", r); end
        wait_idle(9 * 160 + 100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ovf_drain: got busy expected idle within budget"); end
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h2) begin miscompares++; $display("FAIL drained_status: got %h expected 00000002", r); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        int          lat;
        lat = -1;
        bus_wr(2'd2, 32'd4, 4'b0011);
        bus_wr(2'd0, 32'hA5, 4'b0001);
        bus_wr(2'd0, 32'h3C, 4'b0001);
        for (int w = 0; w < 8; w++) begin
            if (uart_tx === 1'b0) begin
                lat = w;
                break;
            end
            @(negedge sys_clk);
        end
        vectors++;
        if (lat < 0) begin miscompares++; $display("FAIL rst_frame_start: got no start bit expected one"); end
        repeat (17) @(negedge sys_clk);
        vectors++;
        if (uart_tx !== 1'b0) begin miscompares++; $display("FAIL rst_bit3: got %b expected 0", uart_tx); end
        #1 sys_resetn = 1'b0;
        #1;
        vectors++;
        if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL rst_async_tx: got %b expected 1", uart_tx); end
        repeat (2) @(negedge sys_clk);
        sys_resetn = 1'b1;
        @(negedge sys_clk);
        bus_rd(2'd1, r);
        vectors++;
        if (r !== 32'h2) begin miscompares++; $display("FAIL rst_status: got %h expected 00000002", r); end
        bus_rd(2'd2, r);
        vectors++;
        if (r !== 32'h1B2) begin miscompares++; $display("FAIL rst_div: got %h expected 000001b2", r); end
        repeat (5) @(negedge sys_clk);
        vectors++;
        if (uart_tx !== 1'b1 || tx_irq !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_quiet: got tx %b irq %b expected 1 1", uart_tx, tx_irq);
        end
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_resetn = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_div_change();
        test_random_frames();
        test_min_div();
        test_strobes();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the picorv32 system bus. Sits directly downstream of the system address decoder.
- The decoder asserts one-cycle read/write selects for the UART window at 0x0000_8010-0x0000_801B. This block consumes the CPU's write data and drives read data back into the CPU read-data mux.
- Bytes written by firmware are buffered in a small FIFO and serialised as 8N1 frames on a single TX pin.

Parameters:
- DEFAULT_DIV, 434, reset value of the baud divisor, in clocks per bit (50 MHz / 115200).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- sys_clk  in  1  system clock
- sys_resetn  in  1  asynchronous active-low reset
- bus_read  in  1  decoder read select for this block; one cycle per access
- bus_write  in  1  decoder write select for this block; one cycle per access
- bus_addr  in  2  word offset: 0=TXDATA, 1=STATUS, 2=BAUDDIV
- bus_wdata  in  32  CPU write data
- bus_wstrb  in  4  CPU byte write strobes
- bus_rdata  out  32  registered read data
- uart_tx  out  1  serial output, idle high
- tx_irq  out  1  high while FIFO is empty and the shifter is idle

Behaviour:
- Reset values:
  - uart_tx=1, bus_rdata=0, tx_irq=1.
  - FIFO empty, divisor=DEFAULT_DIV, overflow flag=0, FSM in IDLE.
  - Reset asserted mid-frame aborts the frame; uart_tx returns to 1 immediately.
- Reads:
  - bus_rdata is updated on the sys_clk edge that ends the bus_read cycle and holds until the next read. This is 1-cycle latency, matching the decoder's one-cycle acknowledge.
  - Read of offset 3: returns 0.
  - Read of TXDATA: returns 0.
  - Read of STATUS: {28'd0, overflow, busy, empty, full}.
  - Read of BAUDDIV: {16'd0, div}.
- Writes:
  - TXDATA: acts only if bus_wstrb[0]=1; pushes bus_wdata[7:0].
  - Push when FIFO is full and no pop occurs in the same cycle: byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: push is accepted, count is unchanged.
  - STATUS: writing 1 to bit 3 with wstrb[0]=1 clears overflow. All other bits are read-only.
  - BAUDDIV: wstrb[0]/[1] update div[7:0]/[15:8]. Values below 2 are stored but used as 2.
  - bus_read and bus_write asserted together: write takes effect; rdata still returns the pre-write value.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, latch the effective divisor, load the bit counter with div-1, go to START.
  - A divisor written mid-frame applies from the next frame.
  - START: uart_tx=0 for div cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0] for div cycles per bit, LSB first. After bit 7, go to STOP.
  - STOP: uart_tx=1 for div cycles. Then, if the FIFO is non-empty, pop the next byte and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
  - Frame length is exactly 10*div cycles.
  - busy = (state != IDLE).
  - full = (count == FIFO_DEPTH). empty = (count == 0).
  - tx_irq = empty & ~busy, registered.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits wide.

Decomposition:
- Shared include uart_defs.vh holds:
  - register offsets: TXDATA=0, STATUS=1, BAUDDIV=2
  - STATUS bit positions: FULL=0, EMPTY=1, BUSY=2, OVF=3
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3
- One sub-module, sync_fifo (WIDTH=8, DEPTH param):
  - ports push, pop, din, dout, full, empty, count
  - dout shows the head entry combinationally
- The register file and the FSM stay in uart_tx_periph.

Test Plan:
- Reset, then read STATUS and BAUDDIV -> rdata 0x0000_0002 (empty), then 0x0000_01B2; uart_tx=1; tx_irq=1.
- div=4; write TXDATA 0xA5 -> uart_tx: low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles. Frame is 40 cycles; busy=1 throughout; tx_irq returns to 1 afterwards.
- div=2; write 0x55, 0x0F back-to-back -> 40 contiguous frame cycles with no idle high between the first stop bit and the second start bit.
- div=16; write 9 bytes quickly:
  - first byte pops after 1 cycle, so all 9 fit and STATUS shows full=1
  - a 10th write -> STATUS overflow=1 (0x...D)
  - write STATUS 0x8 -> overflow=0
- Write BAUDDIV=8 mid-frame at div=4 -> current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Assert sys_resetn=0 during DATA bit 3 -> uart_tx=1 without waiting for a clock edge. After release, FIFO is empty, STATUS=0x2, and div is back to 434.
